// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared data-memory definitions: load op encodings, store
//               width codes, load-unit state enum and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    // Load op encodings; bit 2 selects zero-extension for byte/half loads.
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    // Store width codes used by the store formatter.
    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_H = 2'b10;

    // Load-unit sequencing states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } ld_state_e;

    // True when a word or halfword load is not naturally aligned.
    function automatic logic ld_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic v_mis;
        v_mis = 1'b0;
        if (op == LD_W)
            v_mis = (lane != 2'b00);
        else if ((op == LD_H) || (op == LD_HU))
            v_mis = lane[0];
        return v_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : m_load_ext
// Description : Combinational lane select and sign/zero extension of a
//               32-bit read word for byte, halfword and word loads.
// Revision    : 1.0 - initial release
// ============================================================================
module m_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/half and extend according to the op.
    always_comb begin
        w_byte = 8'h00;
        data   = rdata;
        case (lane)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            LD_B:    data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   data = {24'h000000, w_byte};
            LD_H:    data = {{16{w_half[15]}}, w_half};
            LD_HU:   data = {16'h0000, w_half};
            default: data = rdata;   // LD_W and unknown ops
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : m_load_unit
// Description : M-stage load engine. Issues a word-aligned read to a
//               variable-latency data memory, stalls the pipeline until the
//               response returns, then delivers the extended load result.
//               Optional macro LOAD_ADEL_EN adds misaligned-load detection
//               and the adel exception output.
// Revision    : 1.0 - initial release
// ============================================================================
module m_load_unit
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic [31:0] addr,
    input  logic [2:0]  load_op,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data
`ifdef LOAD_ADEL_EN
    ,
    output logic        adel
`endif
);

    ld_state_e   r_state;
    ld_state_e   w_next;
    logic [1:0]  r_lane;
    logic [2:0]  r_op;
    logic [31:0] r_mem_addr;
    logic [31:0] r_load_data;
    logic [31:0] w_ext;
    logic        w_accept;
    logic        w_capture;
    logic        w_misaligned;
    logic        w_adel;

`ifdef LOAD_ADEL_EN
    assign w_misaligned = ld_misaligned(load_op, addr[1:0]);
    assign adel         = w_adel;
`else
    assign w_misaligned = 1'b0;
`endif

    assign mem_addr  = r_mem_addr;
    assign load_data = r_load_data;

    m_load_ext u_ext (
        .rdata (mem_rdata),
        .lane  (r_lane),
        .op    (r_op),
        .data  (w_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Latch the request attributes when a load is accepted in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane     <= 2'b00;
            r_op       <= LD_W;
            r_mem_addr <= 32'h0000_0000;
        end else if (w_accept) begin
            r_lane     <= addr[1:0];
            r_op       <= load_op;
            r_mem_addr <= {addr[31:2], 2'b00};
        end
    end

    // Capture the extended result when the response returns unflushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_load_data <= 32'h0000_0000;
        else if (w_capture)
            r_load_data <= w_ext;
    end

    // Next-state and output decode.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_adel     = 1'b0;
        mem_req    = 1'b0;
        stall      = 1'b0;
        load_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_req) begin
                    if (w_misaligned) begin
                        w_adel = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        stall    = 1'b1;
                        w_next   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (flush)
                    w_next = mem_ready ? S_DRAIN : S_IDLE;
                else if (mem_ready)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    // Data arriving with the flush is simply dropped.
                    w_next = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // load_req still belongs to the completed load here.
                load_valid = 1'b1;
                w_next     = S_IDLE;
            end
            S_DRAIN: begin
                stall = load_req;
                if (mem_rvalid)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifndef LOAD_ADEL_EN
    // Keep the unused local quiet in the default build.
    logic w_unused;
    assign w_unused = w_adel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_load_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_m_load_unit
// Description : Scoreboard bench for m_load_unit with a reference model of
//               load extraction; directed cases followed by random traffic.
//               Honours LOAD_ADEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_load_unit;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_req;
    logic [31:0] addr;
    logic [2:0]  load_op;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
`ifdef LOAD_ADEL_EN
    logic        adel;
`endif

    logic [31:0] exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;

    always #5 clk = ~clk;

    m_load_unit u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_req   (load_req),
        .addr       (addr),
        .load_op    (load_op),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data)
`ifdef LOAD_ADEL_EN
        ,
        .adel       (adel)
`endif
    );

    // Reference: extract the addressed field with shifts and masks.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] v;
        if (op == LD_B || op == LD_BU) begin
            v = (d >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
            if (op == LD_B && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op == LD_H || op == LD_HU) begin
            v = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (op == LD_H && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] a);
        return (op == LD_W && (a % 4) != 0) || ((op == LD_H || op == LD_HU) && (a % 2) != 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every load_valid pops one expected result.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (reset_n && stall) stall_cnt++;
        if (reset_n && load_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_load_valid: got load_data %h expected no load_valid", load_data);
            end else begin
                e = exp_q.pop_front();
                if (load_data !== e) begin
                    n_fail++;
                    $display("FAIL load_data: got %h expected %h", load_data, e);
                end
            end
        end
    end

    task automatic start_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        load_req  = 1'b1;
        load_op   = op;
        addr      = a;
        stall_cnt = 0;
        exp_q.push_back(ref_load(op, a, d));
    endtask

    // Drive a pending accepted request through memory handshake to completion.
    task automatic finish_load(input logic [31:0] a, input logic [31:0] d,
                               input int rdly, input int vdly, input bit chk_stall);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL mem_req_timeout: got 0 expected 1");
            load_req = 1'b0;
            return;
        end
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        addr    = $urandom;
        load_op = 3'($urandom);
        repeat (rdly) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (vdly) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (load_valid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL load_valid_timeout: got 0 expected 1");
        end
        if (chk_stall) check("stall_cycles", stall_cnt, 3 + rdly + vdly);
        load_req = 1'b0;
        tick();
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int rdly, input int vdly);
        start_load(op, a, d);
        finish_load(a, d, rdly, vdly, 1'b1);
    endtask

    // Flush scenarios: 0 REQ no ready, 1 REQ with ready, 2 WAIT then late data,
    // 3 WAIT with data in the same cycle. Modes 1/2 optionally chain a new LD_W.
    task automatic flush_load(input logic [2:0] op, input logic [31:0] a, input int mode,
                              input int fdly, input bit chain, input logic [31:0] a2,
                              input logic [31:0] d2);
        load_req = 1'b1;
        load_op  = op;
        addr     = a;
        tick();
        if (mode >= 2) begin
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
        flush    = 1'b1;
        load_req = 1'b0;
        if (mode == 1) mem_ready = 1'b1;
        if (mode == 3) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; end
        tick();
        flush      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if (mode == 1 || mode == 2) begin
            if (chain) start_load(LD_W, a2, d2);
            #1;
            check("drain_stall", {31'd0, stall}, {31'd0, chain});
            check("drain_mem_req", {31'd0, mem_req}, 32'd0);
            repeat (fdly) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
            tick();
            mem_rvalid = 1'b0;
            if (chain) finish_load(a2, d2, 0, 1, 1'b0);
            else tick();
        end else begin
            check("flush_idle_mem_req", {31'd0, mem_req}, 32'd0);
            check("flush_idle_stall", {31'd0, stall}, 32'd0);
            tick();
        end
    endtask

`ifdef LOAD_ADEL_EN
    task automatic adel_load(input logic [2:0] op, input logic [31:0] a);
        load_req = 1'b1;
        load_op  = op;
        addr     = a;
        #1;
        check("adel_pulse", {31'd0, adel}, 32'd1);
        check("adel_stall", {31'd0, stall}, 32'd0);
        tick();
        check("adel_mem_req", {31'd0, mem_req}, 32'd0);
        load_req = 1'b0;
        #1;
        check("adel_clear", {31'd0, adel}, 32'd0);
        tick();
    endtask
`endif

    initial begin
        logic [2:0]  ops[8];
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        ops = '{LD_W, LD_B, LD_H, LD_BU, LD_HU, 3'b011, 3'b100, 3'b111};

        reset_n = 1'b0; load_req = 1'b0; addr = '0; load_op = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Directed loads
        do_load(LD_B, 32'h0000_1003, 32'h80AA_55CC, 0, 0);
        do_load(LD_HU, 32'h0000_2002, 32'h9136_ABCD, 2, 2);
        do_load(LD_H, 32'h0000_0000, 32'h0000_8001, 0, 0);
        do_load(LD_BU, 32'h0000_0001, 32'h0000_8001, 1, 0);
        do_load(3'b111, 32'h0000_4000, 32'h1234_5678, 0, 1);

        // Flush in WAIT with late data, new LD_W arriving during drain
        flush_load(LD_W, 32'h0000_5000, 2, 2, 1'b1, 32'h0000_6004, 32'hCAFE_F00D);

        // Reset in WAIT, then a stale response
        load_req = 1'b1; load_op = LD_W; addr = 32'h0000_7000;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        reset_n  = 1'b0;
        load_req = 1'b0;
        #1;
        check("wrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("wrst_mem_addr", mem_addr, 32'd0);
        check("wrst_load_data", load_data, 32'd0);
        check("wrst_load_valid", {31'd0, load_valid}, 32'd0);
        check("wrst_stall", {31'd0, stall}, 32'd0);
`ifdef LOAD_ADEL_EN
        check("wrst_adel", {31'd0, adel}, 32'd0);
`endif
        tick();
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        repeat (2) tick();
        check("stale_rvalid_idle", {31'd0, mem_req | stall | load_valid}, 32'd0);

`ifdef LOAD_ADEL_EN
        adel_load(LD_W, 32'h0000_3002);
        adel_load(LD_HU, 32'h0000_3001);
`endif

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            d  = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                flush_load(op, a & 32'hFFFF_FFFC, int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), 1'($urandom), $urandom & 32'hFFFF_FFFC, d);
            end else begin
`ifdef LOAD_ADEL_EN
                if (ref_misaligned(op, a))
                    adel_load(op, a);
                else
                    do_load(op, a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
`else
                do_load(op, a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
`endif
            end
        end

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
